// File: rtl/fft_frame_sequencer.sv
// Captures one frame of ADC samples, sends the FFT config word, then streams the
// frame as complex AXI4-Stream beats and waits for the FFT to finish.
module fft_frame_sequencer #(
  parameter int              FFT_LEN  = 256,
  parameter int              LOG2_LEN = 8,
  parameter int              DATA_W   = 8,
  parameter int              OUT_W    = 16,
  parameter int              CFG_W    = 8,
  parameter logic [CFG_W-1:0] CFG_WORD = 8'h01
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [DATA_W-1:0]    i_wave_data,
  input  logic                 i_wave_valid,
  output logic                 o_cfg_tvalid,
  output logic [CFG_W-1:0]     o_cfg_tdata,
  input  logic                 i_cfg_tready,
  output logic                 o_data_tvalid,
  output logic [2*OUT_W-1:0]   o_data_tdata,
  output logic                 o_data_tlast,
  input  logic                 i_data_tready,
  input  logic                 i_fft_done,
  output logic                 o_busy,
  output logic [15:0]          o_frame_cnt,
  output logic [15:0]          o_drop_cnt
);

  localparam logic [LOG2_LEN-1:0] LAST_ADDR = LOG2_LEN'(FFT_LEN - 1);
  localparam int                  EXT_W     = OUT_W - DATA_W;

  typedef enum logic [2:0] {IDLE, FILL, CFG, STREAM, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [LOG2_LEN-1:0] wrAddr_q, wrAddr_d;
  logic [LOG2_LEN:0]   rdCnt_q, rdCnt_d;
  logic                pend_q, pend_d, pendLast_q, pendLast_d;
  logic                outValid_q, outValid_d, outLast_q, outLast_d;
  logic [DATA_W-1:0]   outData_q, outData_d;
  logic                skidValid_q, skidValid_d, skidLast_q, skidLast_d;
  logic [DATA_W-1:0]   skidData_q, skidData_d;
  logic [15:0]         frameCnt_q, frameCnt_d, dropCnt_q, dropCnt_d;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [FFT_LEN];
  logic [DATA_W-1:0]   ramQ;
  logic                memWe, rdEn, dataValid, pop;
  logic [LOG2_LEN-1:0] rdAddr;
  logic [1:0]          held;

  assign rdAddr    = rdCnt_q[LOG2_LEN-1:0];
  assign dataValid = outValid_q && (state_q == STREAM);
  assign pop       = dataValid && i_data_tready;

  always_comb begin
    state_d     = state_q;
    wrAddr_d    = wrAddr_q;
    frameCnt_d  = frameCnt_q;
    dropCnt_d   = dropCnt_q;
    rdCnt_d     = rdCnt_q;
    pend_d      = 1'b0;
    pendLast_d  = 1'b0;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidLast_d  = skidLast_q;
    skidData_d  = skidData_q;
    memWe       = 1'b0;
    rdEn        = 1'b0;
    held        = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d  = FILL;
          wrAddr_d = '0;
        end
      end
      FILL: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (i_wave_valid) begin
          memWe    = 1'b1;
          wrAddr_d = wrAddr_q + 1'b1;
          if (wrAddr_q == LAST_ADDR) state_d = CFG;
        end
      end
      CFG: begin
        if (i_cfg_tready) state_d = STREAM;
      end
      STREAM: begin
        if (pop && outLast_q) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_fft_done) begin
          frameCnt_d = frameCnt_q + 16'd1;
          wrAddr_d   = '0;
          state_d    = i_enable ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == CFG || state_q == STREAM || state_q == WAIT_DONE) &&
        i_wave_valid && i_enable && dropCnt_q != 16'hFFFF)
      dropCnt_d = dropCnt_q + 16'd1;

    // Read engine prefetches during CFG; the output + skid registers always have
    // room for the read in flight, so the RAM latency never creates a bubble.
    if (state_q == CFG || state_q == STREAM) begin
      held       = 2'(outValid_q) + 2'(skidValid_q) + 2'(pend_q) - 2'(pop);
      rdEn       = !rdCnt_q[LOG2_LEN] && (held <= 2'd1);
      if (rdEn) rdCnt_d = rdCnt_q + 1'b1;
      pend_d     = rdEn;
      pendLast_d = rdEn && (rdAddr == LAST_ADDR);
      if (!outValid_q || pop) begin
        if (skidValid_q) begin
          outValid_d  = 1'b1;
          outData_d   = skidData_q;
          outLast_d   = skidLast_q;
          skidValid_d = pend_q;
          skidData_d  = ramQ;
          skidLast_d  = pendLast_q;
        end else begin
          outValid_d = pend_q;
          outData_d  = ramQ;
          outLast_d  = pendLast_q;
        end
      end else if (pend_q) begin
        skidValid_d = 1'b1;
        skidData_d  = ramQ;
        skidLast_d  = pendLast_q;
      end
    end else begin
      rdCnt_d     = '0;
      outValid_d  = 1'b0;
      outLast_d   = 1'b0;
      skidValid_d = 1'b0;
      skidLast_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wrAddr_q    <= '0;
      rdCnt_q     <= '0;
      pend_q      <= 1'b0;
      pendLast_q  <= 1'b0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidLast_q  <= 1'b0;
      skidData_q  <= '0;
      frameCnt_q  <= '0;
      dropCnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrAddr_q    <= wrAddr_d;
      rdCnt_q     <= rdCnt_d;
      pend_q      <= pend_d;
      pendLast_q  <= pendLast_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidLast_q  <= skidLast_d;
      skidData_q  <= skidData_d;
      frameCnt_q  <= frameCnt_d;
      dropCnt_q   <= dropCnt_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // Frame buffer: simple dual-port RAM, contents intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (memWe) mem[wrAddr_q] <= i_wave_data;
    if (rdEn)  ramQ <= mem[rdAddr];
  end

  assign o_cfg_tvalid  = (state_q == CFG);
  assign o_cfg_tdata   = (state_q == CFG) ? CFG_WORD : '0;
  assign o_data_tvalid = dataValid;
  assign o_data_tlast  = dataValid && outLast_q;
  assign o_data_tdata  = {{OUT_W{1'b0}}, {EXT_W{outData_q[DATA_W-1]}}, outData_q};
  assign o_busy        = busy_q;
  assign o_frame_cnt   = frameCnt_q;
  assign o_drop_cnt    = dropCnt_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: full frames, backpressure, drops,
// abort, mid-stream reset and boundary sample values.
module tb_fft_frame_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        i_enable;
  logic [7:0]  i_wave_data;
  logic        i_wave_valid;
  logic        o_cfg_tvalid;
  logic [7:0]  o_cfg_tdata;
  logic        i_cfg_tready;
  logic        o_data_tvalid;
  logic [31:0] o_data_tdata;
  logic        o_data_tlast;
  logic        i_data_tready = 1'b1;
  logic        i_fft_done;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;

  fft_frame_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_wave_data(i_wave_data), .i_wave_valid(i_wave_valid),
    .o_cfg_tvalid(o_cfg_tvalid), .o_cfg_tdata(o_cfg_tdata), .i_cfg_tready(i_cfg_tready),
    .o_data_tvalid(o_data_tvalid), .o_data_tdata(o_data_tdata), .o_data_tlast(o_data_tlast),
    .i_data_tready(i_data_tready), .i_fft_done(i_fft_done),
    .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  int          cycle = 0;
  int          cfgBeats = 0;
  int          cfgCycle = 0;
  logic [7:0]  cfgData = 8'h00;
  int          stallErrs = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData = 32'h0;
  logic        prevLast = 1'b0;
  int          assertCount = 0;
  int          failCount = 0;
  logic [7:0]  expS [256];
  logic        bpMode = 1'b0;
  int          expFrames = 0;
  int          base;
  int          cfgBase;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #1;
    i_data_tready = bpMode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: records handshakes mid-cycle and flags any change while stalled.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prevStall = 1'b0;
    end else begin
      cycle++;
      if (prevStall && (!o_data_tvalid || o_data_tdata !== prevData || o_data_tlast !== prevLast))
        stallErrs++;
      prevStall = o_data_tvalid && !i_data_tready;
      prevData  = o_data_tdata;
      prevLast  = o_data_tlast;
      if (o_data_tvalid && i_data_tready)
        beats.push_back('{o_data_tdata, o_data_tlast, cycle});
      if (o_cfg_tvalid && i_cfg_tready) begin
        cfgBeats++;
        cfgData  = o_cfg_tdata;
        cfgCycle = cycle;
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] expBeat(input logic [7:0] s);
    return {16'h0000, {8{s[7]}}, s};
  endfunction

  function automatic logic [31:0] beatAt(input int idx);
    return (idx < beats.size()) ? beats[idx].data : 32'hDEADBEEF;
  endfunction

  function automatic int cycAt(input int idx);
    return (idx < beats.size()) ? beats[idx].cyc : -100000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic v, input logic [7:0] d, input logic done);
    i_enable     = en;
    i_wave_valid = v;
    i_wave_data  = d;
    i_fft_done   = done;
    @(posedge i_clk);
    #1;
    i_wave_valid = 1'b0;
    i_fft_done   = 1'b0;
  endtask

  task automatic fillFrame(input logic [7:0] start, input bit special, input bit stray);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] s;
      s = start + 8'(k);
      if (special && k == 0) s = 8'h7F;
      if (special && k == 1) s = 8'h80;
      expS[k] = s;
      applyStimulus(1'b1, 1'b1, s, stray && (k == 10 || k == 20));
    end
  endtask

  task automatic waitBeats(input int n, input string tag);
    int guard;
    guard = 0;
    while (beats.size() < n && guard < 5000) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    checkOutput(tag, beats.size(), n);
  endtask

  task automatic checkFrame(input string tag, input int b);
    int errs;
    int lasts;
    errs  = 0;
    lasts = 0;
    checkOutput({tag, "_count"}, beats.size() - b, 256);
    for (int k = 0; k < 256; k++) begin
      if (b + k >= beats.size()) begin
        errs++;
      end else begin
        if (beats[b+k].data !== expBeat(expS[k])) errs++;
        if (beats[b+k].last) lasts++;
        if (beats[b+k].last !== (k == 255)) errs++;
      end
    end
    checkOutput({tag, "_data"}, errs, 0);
    checkOutput({tag, "_tlast_cnt"}, lasts, 1);
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_wave_valid = 1'b0; i_wave_data = 8'h00;
    i_cfg_tready = 1'b0; i_fft_done = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_busy", 32'(o_busy), 0);
    checkOutput("rst_frame_cnt", 32'(o_frame_cnt), 0);
    checkOutput("rst_drop_cnt", 32'(o_drop_cnt), 0);
    checkOutput("rst_cfg_tvalid", 32'(o_cfg_tvalid), 0);
    checkOutput("rst_cfg_tdata", 32'(o_cfg_tdata), 0);
    checkOutput("rst_data_tvalid", 32'(o_data_tvalid), 0);
    checkOutput("rst_data_tlast", 32'(o_data_tlast), 0);
    checkOutput("rst_data_tdata", o_data_tdata, 0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] full frame, no backpressure");
    i_cfg_tready = 1'b1;
    cfgBase = cfgBeats;
    base = beats.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("f1_busy_fill", 32'(o_busy), 1);
    fillFrame(8'd0, 1'b0, 1'b0);
    checkOutput("f1_cfg_valid", 32'(o_cfg_tvalid), 1);
    checkOutput("f1_cfg_tdata", 32'(o_cfg_tdata), 32'h01);
    i_enable = 1'b0;
    waitBeats(base + 256, "f1_wait");
    checkFrame("f1", base);
    checkOutput("f1_cfg_beats", cfgBeats - cfgBase, 1);
    checkOutput("f1_cfg_word", 32'(cfgData), 32'h01);
    checkOutput("f1_beat200", beatAt(base + 200), 32'h0000FFC8);
    checkOutput("f1_back_to_back", cycAt(base + 255) - cycAt(base), 255);
    checkOutput("f1_cfg_to_data_le2",
                32'((cycAt(base) - cfgCycle <= 2) && (cycAt(base) > cfgCycle)), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f1_frame_cnt", 32'(o_frame_cnt), expFrames);
    checkOutput("f1_busy_idle", 32'(o_busy), 0);

    $display("[TB] backpressure");
    bpMode = 1'b1;
    i_cfg_tready = 1'b0;
    cfgBase = cfgBeats;
    base = beats.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    fillFrame(8'd0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("f2_cfg_held", 32'(o_cfg_tvalid), 1);
    checkOutput("f2_no_cfg_yet", cfgBeats - cfgBase, 0);
    checkOutput("f2_no_early_beats", beats.size() - base, 0);
    i_cfg_tready = 1'b1;
    waitBeats(base + 256, "f2_wait");
    checkFrame("f2", base);
    checkOutput("f2_cfg_beats", cfgBeats - cfgBase, 1);
    checkOutput("f2_stall_stable", stallErrs, 0);
    bpMode = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f2_frame_cnt", 32'(o_frame_cnt), expFrames);

    $display("[TB] drops while busy");
    base = beats.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    fillFrame(8'd50, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    waitBeats(base + 256, "f3_wait_a");
    checkFrame("f3a", base);
    repeat (20) applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    checkOutput("f3_frame_cnt_waiting", 32'(o_frame_cnt), expFrames);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f3_drop_cnt", 32'(o_drop_cnt), 40);
    base = beats.size();
    fillFrame(8'd100, 1'b0, 1'b0);
    i_enable = 1'b0;
    waitBeats(base + 256, "f3_wait_b");
    checkFrame("f3b", base);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f3_frame_cnt", 32'(o_frame_cnt), expFrames);
    checkOutput("f3_drop_cnt_after", 32'(o_drop_cnt), 40);

    $display("[TB] abort during fill");
    base = beats.size();
    cfgBase = cfgBeats;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 100; k++) applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
    checkOutput("f4_busy_fill", 32'(o_busy), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("f4_idle_next", 32'(o_busy), 0);
    repeat (10) applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    checkOutput("f4_no_beats", beats.size() - base, 0);
    checkOutput("f4_no_cfg", cfgBeats - cfgBase, 0);
    checkOutput("f4_frame_cnt", 32'(o_frame_cnt), expFrames);
    checkOutput("f4_drop_cnt", 32'(o_drop_cnt), 40);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    fillFrame(8'd200, 1'b0, 1'b0);
    i_enable = 1'b0;
    waitBeats(base + 256, "f4_wait");
    checkFrame("f4", base);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f4_frame_cnt_after", 32'(o_frame_cnt), expFrames);

    $display("[TB] reset mid-stream");
    base = beats.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    fillFrame(8'd30, 1'b0, 1'b0);
    i_enable = 1'b0;
    waitBeats(base + 50, "f5_wait50");
    i_rst = 1'b1;
    #1;
    checkOutput("f5_rst_busy", 32'(o_busy), 0);
    checkOutput("f5_rst_frame_cnt", 32'(o_frame_cnt), 0);
    checkOutput("f5_rst_drop_cnt", 32'(o_drop_cnt), 0);
    checkOutput("f5_rst_data_tvalid", 32'(o_data_tvalid), 0);
    checkOutput("f5_rst_cfg_tvalid", 32'(o_cfg_tvalid), 0);
    checkOutput("f5_rst_tlast", 32'(o_data_tlast), 0);
    checkOutput("f5_rst_tdata", o_data_tdata, 0);
    @(posedge i_clk);
    #1;
    checkOutput("f5_rst_hold_busy", 32'(o_busy), 0);
    checkOutput("f5_rst_hold_tvalid", 32'(o_data_tvalid), 0);
    i_rst = 1'b0;
    expFrames = 0;
    base = beats.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    fillFrame(8'd60, 1'b0, 1'b0);
    i_enable = 1'b0;
    waitBeats(base + 256, "f5_wait");
    checkFrame("f5", base);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f5_frame_cnt", 32'(o_frame_cnt), expFrames);

    $display("[TB] stray done pulses and extreme samples");
    base = beats.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    fillFrame(8'd5, 1'b1, 1'b1);
    checkOutput("f6_stray_done_ignored", 32'(o_frame_cnt), expFrames);
    i_enable = 1'b0;
    waitBeats(base + 256, "f6_wait");
    checkFrame("f6", base);
    checkOutput("f6_re_127", beatAt(base), 32'h0000007F);
    checkOutput("f6_re_m128", beatAt(base + 1), 32'h0000FF80);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expFrames++;
    checkOutput("f6_frame_cnt", 32'(o_frame_cnt), expFrames);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
